// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, IF/ID register, stall/flush/redirect/halt
module fetch_stage #(
  parameter int                          REG_WIDTH           = 32,
  parameter int                          INSTR_ADDR_WIDTH    = 32,
  parameter int                          NUM_OF_INSTRUCTIONS = 128,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC            = '0,
  parameter logic [REG_WIDTH-1:0]        NOP_WORD            = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
  input  logic [REG_WIDTH-1:0]        imem_instr,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        redirect_valid,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_target,
  output logic                        ifid_valid,
  output logic [REG_WIDTH-1:0]        ifid_instr,
  output logic [INSTR_ADDR_WIDTH-1:0] ifid_pc,
  output logic [INSTR_ADDR_WIDTH-1:0] ifid_pc_next,
  output logic                        fetch_halted,
  output logic [31:0]                 fetch_count
);

  localparam logic [INSTR_ADDR_WIDTH-1:0] PC_LIMIT = INSTR_ADDR_WIDTH'(NUM_OF_INSTRUCTIONS);

  logic [INSTR_ADDR_WIDTH-1:0] pc;
  logic [INSTR_ADDR_WIDTH-1:0] pc_plus1;

  // pc_plus1 wraps naturally; the range check alone decides whether that halts fetch
  assign pc_plus1     = pc + 1'b1;
  assign imem_addr    = pc;
  assign fetch_halted = (pc >= PC_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      ifid_valid   <= 1'b0;
      ifid_instr   <= NOP_WORD;
      ifid_pc      <= '0;
      ifid_pc_next <= '0;
      fetch_count  <= '0;
    end else if (redirect_valid) begin
      // the word on imem_instr this cycle is wrong-path, so it becomes a bubble
      pc         <= redirect_target;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_WORD;
    end else if (flush) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_WORD;
      if (!stall && !fetch_halted) begin
        pc <= pc_plus1;
      end
    end else if (stall) begin
      pc <= pc;
    end else if (fetch_halted) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_WORD;
    end else begin
      ifid_valid   <= 1'b1;
      ifid_instr   <= imem_instr;
      ifid_pc      <= pc;
      ifid_pc_next <= pc_plus1;
      pc           <= pc_plus1;
      if (fetch_count != 32'hFFFF_FFFF) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_next;
  logic        fetch_halted;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pc_next    (ifid_pc_next),
    .fetch_halted    (fetch_halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | (a & 32'h0000_FFFF);
  endfunction

  assign imem_instr = (imem_addr < 32'd128) ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc_exp, input logic [31:0] fc_exp,
                            input logic [31:0] addr_exp);
    check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
    check({tag, "_instr"}, ifid_instr, mem_word(pc_exp));
    check({tag, "_pc"}, ifid_pc, pc_exp);
    check({tag, "_pc_next"}, ifid_pc_next, pc_exp + 32'd1);
    check({tag, "_count"}, fetch_count, fc_exp);
    check({tag, "_addr"}, imem_addr, addr_exp);
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] addr_exp, input logic [31:0] fc_exp);
    check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
    check({tag, "_instr"}, ifid_instr, 32'd0);
    check({tag, "_addr"}, imem_addr, addr_exp);
    check({tag, "_count"}, fetch_count, fc_exp);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;

    #12;
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, 32'd0);
    check("rst_pc", ifid_pc, 32'd0);
    check("rst_pc_next", ifid_pc_next, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_halted", {31'd0, fetch_halted}, 32'd0);
    rst_n = 1'b1;

    // sequential fetch of A, B, C
    step(); check_ifid("seq0", 32'd0, 32'd1, 32'd1);
    step(); check_ifid("seq1", 32'd1, 32'd2, 32'd2);
    step(); check_ifid("seq2", 32'd2, 32'd3, 32'd3);

    // stall held three cycles with ifid_pc=2
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_ifid("stall", 32'd2, 32'd3, 32'd3);
    end
    stall = 1'b0;
    step(); check_ifid("unstall", 32'd3, 32'd4, 32'd4);
    step(); check_ifid("seq4", 32'd4, 32'd5, 32'd5);

    // flush + stall at PC=5: bubble, PC holds, ifid_pc/pc_next hold
    flush = 1'b1; stall = 1'b1;
    step(); check_bubble("flush_stall", 32'd5, 32'd5);
    check("flush_stall_pc", ifid_pc, 32'd4);
    check("flush_stall_pc_next", ifid_pc_next, 32'd5);
    flush = 1'b0; stall = 1'b0;
    step(); check_ifid("after_fs", 32'd5, 32'd6, 32'd6);

    // flush alone advances PC
    flush = 1'b1;
    step(); check_bubble("flush_only", 32'd7, 32'd6);
    flush = 1'b0;
    step(); check_ifid("after_flush", 32'd7, 32'd7, 32'd8);

    // redirect to 20 with stall in the same cycle
    redirect_valid = 1'b1; redirect_target = 32'd20; stall = 1'b1;
    step(); check_bubble("redir20", 32'd20, 32'd7);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); check_ifid("at20", 32'd20, 32'd8, 32'd21);

    // run up to PC=127
    for (int i = 0; i < 200 && imem_addr != 32'd127; i++) step();
    check("reach127_addr", imem_addr, 32'd127);
    check("reach127_count", fetch_count, 32'd114);
    check("reach127_halted", {31'd0, fetch_halted}, 32'd0);
    step(); check_ifid("last", 32'd127, 32'd115, 32'd128);
    check("halt_set", {31'd0, fetch_halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(); check_bubble("halted", 32'd128, 32'd115);
      check("halted_flag", {31'd0, fetch_halted}, 32'd1);
      check("halted_pc", ifid_pc, 32'd127);
    end

    // redirect clears halt
    redirect_valid = 1'b1; redirect_target = 32'd0;
    step(); check_bubble("redir0", 32'd0, 32'd115);
    check("redir0_halted", {31'd0, fetch_halted}, 32'd0);
    redirect_valid = 1'b0;
    step(); check_ifid("resume0", 32'd0, 32'd116, 32'd1);

    // wrapped-range target also halts
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step(); check("wrap_halted", {31'd0, fetch_halted}, 32'd1);
    redirect_valid = 1'b0;
    step(); check_bubble("wrap_hold", 32'hFFFF_FFFF, 32'd116);
    redirect_valid = 1'b1; redirect_target = 32'd1;
    step();
    redirect_valid = 1'b0;

    // run to PC=9, then asynchronous reset mid-cycle
    for (int i = 0; i < 50 && imem_addr != 32'd9; i++) step();
    check("reach9_addr", imem_addr, 32'd9);
    check("reach9_count", fetch_count, 32'd124);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_addr", imem_addr, 32'd0);
    check("arst_valid", {31'd0, ifid_valid}, 32'd0);
    check("arst_instr", ifid_instr, 32'd0);
    check("arst_pc", ifid_pc, 32'd0);
    check("arst_pc_next", ifid_pc_next, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    step();
    #2;
    rst_n = 1'b1;
    step(); check_ifid("restart", 32'd0, 32'd1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
